// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder made of two half adders and an OR; the single cell reused every bit.
module serial_fa_cell (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic c
);

  logic hs, hc0, hc1;

  assign hs   = a ^ b;
  assign hc0  = a & b;
  assign sum  = hs ^ c;
  assign hc1  = hs & c;
  assign cout = hc0 | hc1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: accept in IDLE, WIDTH shift cycles in RUN, result held in DONE until out_ready.
// SERIAL_ADDER_SUB_EN adds a sub port selecting a - b (captured inverted b, initial carry 1).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic             rdy_en;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cell_s, cell_c;
  logic             accept, last_bit, sub_eff;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  serial_fa_cell u_cell (
    .sum  (cell_s),
    .cout (cell_c),
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (carry)
  );

  assign accept   = in_valid && in_ready;
  assign last_bit = (state == ST_RUN) && (cnt == CNT_LAST);
  assign sum_nxt  = {cell_s, sum_sh};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Keeps in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub_eff ? ~b : b;
      carry <= sub_eff ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_nxt[WIDTH-1:1];
      carry  <= cell_c;
      if (!last_bit) cnt <= cnt + CNT_W'(1);
      // Outputs only update on the final bit so they stay stable outside DONE.
      if (last_bit) begin
        sum  <= sum_nxt;
        cout <= cell_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, corner sequences, random ops.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: addition is a+b+cin; subtraction is a-b offset by 2^8 so bit 8 means no borrow.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic c, input logic s);
    int r;
    if (s) r = 256 + int'(x) - int'(y);
    else   r = int'(x) + int'(y) + int'(c);
    return 9'(r);
  endfunction

  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input logic ts, input logic ordy);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`else
    if (ts) chk("sub_unsupported", 32'(ts), 32'd0);
`endif
    out_ready = ordy;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tc;
  endtask

  // lat counts rising edges from the accept edge (inclusive) up to the one raising out_valid.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic ts, input int bp,
                        output logic [7:0] rs, output logic rc, output int lat,
                        output logic idle_ok, output logic hold_ok);
    start_op(ta, tb_, tc, ts, bp == 0);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rs = sum;
    rc = cout;
    hold_ok = 1'b1;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      if (!out_valid || in_ready || sum !== rs || cout !== rc) hold_ok = 1'b0;
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
    end
    if (bp > 0) begin
      @(negedge clk);
      if (!out_valid || in_ready || sum !== rs || cout !== rc) hold_ok = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    idle_ok = in_ready && !out_valid;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) chk(name, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rs;
    logic       rc, idle_ok, hold_ok;
    int         lat;
    logic [7:0] ra, rb;
    logic       rci, rsb;
    logic [8:0] exp;
    int         bp;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif

    tbl.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0});
    tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
    tbl.push_back('{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    tbl.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0});
    tbl.push_back('{8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    tbl.push_back('{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0});
    tbl.push_back('{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    chk("out_valid_after_rst", 32'(out_valid), 32'd0);

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 0, rs, rc, lat, idle_ok, hold_ok);
      chk($sformatf("tbl%0d_sum", i), 32'(rs), 32'(tbl[i].s));
      chk($sformatf("tbl%0d_cout", i), 32'(rc), 32'(tbl[i].co));
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd9);
      chk($sformatf("tbl%0d_idle", i), 32'(idle_ok), 32'd1);
    end

    // Backpressure for 20 cycles with ignored in_valid pulses during DONE.
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 20, rs, rc, lat, idle_ok, hold_ok);
    chk("bp_sum", 32'(rs), 32'h00);
    chk("bp_cout", 32'(rc), 32'd1);
    chk("bp_hold", 32'(hold_ok), 32'd1);
    chk("bp_idle", 32'(idle_ok), 32'd1);
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, rs, rc, lat, idle_ok, hold_ok);
    chk("post_bp_sum", 32'({rc, rs}), 32'h010);

    // Reset during RUN aborts the op.
    start_op(8'h3C, 8'h11, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_run_out_valid", 32'(out_valid), 32'd0);
    chk("abort_run_in_ready", 32'(in_ready), 32'd0);
    chk("abort_run_sum", 32'(sum), 32'd0);
    chk("abort_run_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h03, 8'h04, 1'b0, 1'b0, 0, rs, rc, lat, idle_ok, hold_ok);
    chk("after_abort_sum", 32'({rc, rs}), 32'h007);
    chk("after_abort_latency", 32'(lat), 32'd9);

    // Reset during DONE drops out_valid without waiting for an edge.
    start_op(8'hF0, 8'h20, 1'b0, 1'b0, 1'b0);
    wait_valid("done_wait_timeout");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_done_out_valid", 32'(out_valid), 32'd0);
    chk("abort_done_sum", 32'(sum), 32'd0);
    chk("abort_done_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rci = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rsb = 1'($urandom);
`else
      rsb = 1'b0;
`endif
      bp  = int'($urandom_range(0, 3));
      exp = model(ra, rb, rci, rsb);
      run_op(ra, rb, rci, rsb, bp, rs, rc, lat, idle_ok, hold_ok);
      chk($sformatf("rnd%0d_result a=%0h b=%0h c=%0b s=%0b", i, ra, rb, rci, rsb),
          32'({rc, rs}), 32'(exp));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd9);
      chk($sformatf("rnd%0d_hold", i), 32'(hold_ok), 32'd1);
      chk($sformatf("rnd%0d_idle", i), 32'(idle_ok), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
